// File: rtl/fetch_sequencer_pkg.sv
// Core-wide encodings shared by the front end and the control unit:
// pipeline stage codes, PC-source selects and instruction field positions.
package fetch_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd5
    } stage_e;

    typedef enum logic [1:0] {
        BR_SEQ   = 2'b00,
        BR_STACK = 2'b01,
        BR_JUMP  = 2'b10
    } branch_e;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int FN_HI  = 5;
    localparam int FN_LO  = 0;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory fetch handshake: the sequencer requests a word address
// and the memory acknowledges with the instruction word in the same cycle.
interface fetch_sequencer_if #(
    parameter int ADDR_W = 16
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_sequencer_return_addr_stack.sv
// Return-address stack for call/ret. A push when full and a pop when empty
// are dropped here; the sequencer raises the sticky flags.
module return_addr_stack #(
    parameter int RAS_DEPTH = 8,
    parameter int ADDR_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] data_in,
    output logic [ADDR_W-1:0] top,
    output logic              full,
    output logic              empty
);
    localparam int PTR_W = $clog2(RAS_DEPTH);

    logic [ADDR_W-1:0] mem [RAS_DEPTH];
    logic [PTR_W:0]    count;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    assign full   = (count == (PTR_W + 1)'(RAS_DEPTH));
    assign empty  = (count == '0);
    assign wr_ptr = count[PTR_W-1:0];
    assign rd_ptr = wr_ptr - 1'b1;
    assign top    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + 1'b1;
        end else if (pop && !empty) begin
            count <= count - 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; entries above count are never read.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr] <= data_in;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle front end: owns PC and IR, fetches over the imem handshake,
// steps IF..WB and resolves the next PC (sequential/call/ret/jump/halt) in WB.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                RAS_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_sequencer_if.master  imem,
    input  logic [1:0]         branch,
    input  logic               push,
    input  logic               pop,
    input  logic               cond_ok,
    input  logic [ADDR_W-1:0]  jump_target,
    input  logic               halt,
    output logic [5:0]         opcode,
    output logic [5:0]         fnction,
    output logic [31:0]        instr,
    output logic [2:0]         stage,
    output logic [ADDR_W-1:0]  pc,
    output logic               ras_ovf,
    output logic               ras_unf
);
    stage_e            state;
    stage_e            state_next;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] pc_inc;
    logic [31:0]       ir;
    logic              ovf_q;
    logic              unf_q;

    logic              wb_active;
    logic              stack_sel;
    logic              take_push;
    logic              take_pop;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_full;
    logic              ras_empty;

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IF;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: defaulting every comb output first keeps incomplete branches from inferring latches.
    always_comb begin
        state_next = state;
        case (state)
            ST_IF:   if (imem.imem_ack) state_next = ST_ID;
            ST_ID:   state_next = ST_EX;
            ST_EX:   state_next = ST_MEM;
            ST_MEM:  state_next = ST_WB;
            ST_WB:   state_next = halt ? ST_HALT : ST_IF;
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_IF;
        endcase
    end

    // Request is gated by rst_n so a fetch drops the instant reset asserts.
    always_comb begin
        imem.imem_req  = rst_n && (state == ST_IF);
        imem.imem_addr = pc_q;
        stage          = state;
        pc             = pc_q;
        instr          = ir;
        opcode         = ir[OPC_HI:OPC_LO];
        fnction        = ir[FN_HI:FN_LO];
        ras_ovf        = ovf_q;
        ras_unf        = unf_q;
    end

    // WB decisions; push wins over pop when the control unit asserts both.
    assign wb_active = (state == ST_WB) && !halt;
    assign stack_sel = (branch == BR_STACK);
    assign take_push = wb_active && stack_sel && push;
    assign take_pop  = wb_active && stack_sel && pop && !push;
    assign pc_inc    = pc_q + 1'b1;

    always_comb begin
        pc_next = pc_q;
        if (wb_active) begin
            if (stack_sel && push) begin
                pc_next = jump_target;
            end else if (stack_sel && pop) begin
                pc_next = ras_empty ? pc_inc : ras_top;
            end else if ((branch == BR_JUMP) && cond_ok) begin
                pc_next = jump_target;
            end else begin
                pc_next = pc_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= RESET_PC;
            ir    <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q <= pc_next;
            if ((state == ST_IF) && imem.imem_ack) begin
                ir <= imem.imem_rdata;
            end
            if (take_push && ras_full) begin
                ovf_q <= 1'b1;
            end
            if (take_pop && ras_empty) begin
                unf_q <= 1'b1;
            end
        end
    end

    return_addr_stack #(
        .RAS_DEPTH (RAS_DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_ras (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (take_push),
        .pop     (take_pop),
        .data_in (pc_inc),
        .top     (ras_top),
        .full    (ras_full),
        .empty   (ras_empty)
    );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a monitor checks fetch addresses and
// latched instructions against scoreboard queues filled by the stimulus.
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  branch = 2'b00;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic        cond_ok = 1'b0;
    logic [15:0] jump_target = 16'h0000;
    logic        halt = 1'b0;
    logic [5:0]  opcode;
    logic [5:0]  fnction;
    logic [31:0] instr;
    logic [2:0]  stage;
    logic [15:0] pc;
    logic        ras_ovf;
    logic        ras_unf;

    fetch_sequencer_if #(.ADDR_W(16)) imem ();

    fetch_sequencer #(
        .ADDR_W    (16),
        .RESET_PC  (16'h0000),
        .RAS_DEPTH (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (imem),
        .branch      (branch),
        .push        (push),
        .pop         (pop),
        .cond_ok     (cond_ok),
        .jump_target (jump_target),
        .halt        (halt),
        .opcode      (opcode),
        .fnction     (fnction),
        .instr       (instr),
        .stage       (stage),
        .pc          (pc),
        .ras_ovf     (ras_ovf),
        .ras_unf     (ras_unf)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] W_RTYPE = 32'h0043_2820;
    localparam logic [31:0] W_CALL  = 32'h0C00_0000;
    localparam logic [31:0] W_RET   = 32'h0000_0008;
    localparam logic [31:0] W_JUMP  = 32'h0800_0000;
    localparam logic [31:0] W_HALT  = 32'hFC00_003F;

    int          n_pass = 0;
    int          n_total = 0;
    logic [15:0] exp_pc_q [$];
    logic [31:0] exp_ir_q [$];
    logic [31:0] last_instr = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Monitor: compares fetch address on IF entry and the latched IR on ID entry.
    logic [2:0] prev_stage = 3'd7;
    always @(negedge clk) begin
        logic [15:0] e_pc;
        logic [31:0] e_ir;
        if (!rst_n) begin
            prev_stage = 3'd7;
        end else begin
            if (stage == 3'd0 && prev_stage != 3'd0) begin
                if (exp_pc_q.size() == 0) begin
                    n_total++;
                    $display("FAIL fetch_addr: unexpected fetch at %h, none expected", imem.imem_addr);
                end else begin
                    e_pc = exp_pc_q.pop_front();
                    check("fetch_addr", 32'(imem.imem_addr), 32'(e_pc));
                end
            end
            if (stage == 3'd1 && prev_stage != 3'd1) begin
                if (exp_ir_q.size() == 0) begin
                    n_total++;
                    $display("FAIL ir_latch: unexpected decode of %h, none expected", instr);
                end else begin
                    e_ir = exp_ir_q.pop_front();
                    check("ir_latch", instr, e_ir);
                    check("opcode", 32'(opcode), 32'(e_ir[31:26]));
                    check("fnction", 32'(fnction), 32'(e_ir[5:0]));
                end
            end
            prev_stage = stage;
        end
    end

    // One instruction from the first IF cycle through WB; returns on the next IF/HALT negedge.
    task automatic run_instr(input logic [31:0] word, input int delay, input logic [1:0] br,
                             input logic ps, input logic pp, input logic co,
                             input logic [15:0] tgt, input logic hl, input logic [15:0] nxt);
        logic [15:0] a0;
        a0 = imem.imem_addr;
        check("stage_if", 32'(stage), 32'(ST_IF));
        for (int i = 0; i < delay; i++) begin
            check("req_wait", 32'(imem.imem_req), 32'd1);
            check("addr_stable", 32'(imem.imem_addr), 32'(a0));
            check("ir_hold_wait", instr, last_instr);
            @(negedge clk);
        end
        check("req_ack", 32'(imem.imem_req), 32'd1);
        imem.imem_ack   = 1'b1;
        imem.imem_rdata = word;
        exp_ir_q.push_back(word);
        @(negedge clk);
        last_instr = word;
        check("stage_id", 32'(stage), 32'(ST_ID));
        check("req_id", 32'(imem.imem_req), 32'd0);
        imem.imem_rdata = ~word;
        @(negedge clk);
        imem.imem_ack = 1'b0;
        check("stage_ex", 32'(stage), 32'(ST_EX));
        check("ir_stray_ack", instr, word);
        @(negedge clk);
        check("stage_mem", 32'(stage), 32'(ST_MEM));
        branch = BR_JUMP; cond_ok = 1'b1; jump_target = 16'h5555;
        push = 1'b1; pop = 1'b1; halt = 1'b1;
        @(negedge clk);
        check("stage_wb", 32'(stage), 32'(ST_WB));
        check("pc_hold_mem", 32'(pc), 32'(a0));
        branch = br; push = ps; pop = pp; cond_ok = co; jump_target = tgt; halt = hl;
        if (!hl) exp_pc_q.push_back(nxt);
        @(negedge clk);
        branch = BR_SEQ; push = 1'b0; pop = 1'b0; cond_ok = 1'b0;
        jump_target = 16'h0000; halt = 1'b0;
        check("stage_after_wb", 32'(stage), hl ? 32'(ST_HALT) : 32'(ST_IF));
        check("pc_next", 32'(pc), 32'(nxt));
        check("ir_stable", instr, word);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] p [0:9];
        imem.imem_ack   = 1'b0;
        imem.imem_rdata = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req", 32'(imem.imem_req), 32'd0);
        check("rst_stage", 32'(stage), 32'(ST_IF));
        check("rst_pc", 32'(pc), 32'h0);
        check("rst_ir", instr, 32'h0);
        check("rst_flags", {30'b0, ras_ovf, ras_unf}, 32'h0);
        exp_pc_q.push_back(16'h0000);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);

        // Four sequential r-type instructions, zero-wait ack
        for (int i = 0; i < 4; i++)
            run_instr(W_RTYPE + 32'(i), 0, BR_SEQ, 0, 0, 0, 16'h0, 0, 16'(i + 1));

        // Ack delayed 3 cycles at pc 4
        run_instr(W_RTYPE, 3, BR_SEQ, 0, 0, 0, 16'h0, 0, 16'h0005);

        // Call at 5 -> 20, ret at 20 -> 6
        run_instr(W_CALL, 0, BR_STACK, 1, 0, 1, 16'd20, 0, 16'd20);
        run_instr(W_RET, 1, BR_STACK, 0, 1, 0, 16'h0, 0, 16'd6);
        check("no_flags_after_ret", {30'b0, ras_ovf, ras_unf}, 32'h0);

        // Nine nested calls from pc 6 into an 8-deep stack
        p[0] = 16'd6;
        for (int i = 0; i < 9; i++) begin
            p[i + 1] = 16'h0100 + 16'(i) * 16'h0010;
            run_instr(W_CALL, 0, BR_STACK, 1, 0, 0, p[i + 1], 0, p[i + 1]);
            check("ras_ovf_call", 32'(ras_ovf), (i == 8) ? 32'd1 : 32'd0);
        end
        // Eight good returns (to p[7]+1 .. p[0]+1), then an underflow at pc 7
        for (int k = 0; k < 9; k++) begin
            run_instr(W_RET, 0, BR_STACK, 0, 1, 0, 16'h0, 0,
                      (k < 8) ? (p[7 - k] + 16'd1) : 16'd8);
            check("ras_unf_ret", 32'(ras_unf), (k == 8) ? 32'd1 : 32'd0);
        end

        // Conditional jumps and PC wrap
        run_instr(W_RTYPE, 0, BR_SEQ, 0, 0, 0, 16'h0, 0, 16'd9);
        run_instr(W_RTYPE, 0, BR_SEQ, 0, 0, 0, 16'h0, 0, 16'd10);
        run_instr(W_JUMP, 0, BR_JUMP, 0, 0, 0, 16'h0003, 0, 16'd11);
        run_instr(W_JUMP, 0, BR_JUMP, 0, 0, 1, 16'h0003, 0, 16'd3);
        run_instr(W_JUMP, 0, BR_JUMP, 0, 0, 1, 16'hFFFF, 0, 16'hFFFF);
        run_instr(W_RTYPE, 0, BR_SEQ, 0, 0, 0, 16'h0, 0, 16'h0000);

        // push and pop together behave as push; the following ret returns to 1
        run_instr(W_CALL, 0, BR_STACK, 1, 1, 0, 16'h0040, 0, 16'h0040);
        run_instr(W_RET, 0, BR_STACK, 0, 1, 0, 16'h0, 0, 16'h0001);

        // Halt outranks a taken jump; HALT ignores everything for 20 cycles
        run_instr(W_HALT, 0, BR_JUMP, 0, 0, 1, 16'h0077, 1, 16'h0001);
        for (int i = 0; i < 20; i++) begin
            imem.imem_ack = 1'b1; imem.imem_rdata = 32'h1234_5678 + 32'(i);
            branch = BR_STACK; push = 1'b1; jump_target = 16'h0999;
            @(negedge clk);
            check("halt_stage", 32'(stage), 32'(ST_HALT));
            check("halt_req", 32'(imem.imem_req), 32'd0);
            check("halt_pc", 32'(pc), 32'h1);
            check("halt_ir", instr, W_HALT);
        end
        imem.imem_ack = 1'b0; branch = BR_SEQ; push = 1'b0; jump_target = 16'h0;

        // Reset from HALT
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        check("rst2_pc", 32'(pc), 32'h0);
        check("rst2_stage", 32'(stage), 32'(ST_IF));
        check("rst2_req", 32'(imem.imem_req), 32'd0);
        check("rst2_flags", {30'b0, ras_ovf, ras_unf}, 32'h0);
        check("rst2_ir", instr, 32'h0);
        last_instr = 32'h0;
        exp_pc_q.push_back(16'h0000);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        run_instr(W_RTYPE, 0, BR_SEQ, 0, 0, 0, 16'h0, 0, 16'h0001);

        @(negedge clk);
        check("sb_pc_drained", 32'(exp_pc_q.size()), 32'd0);
        check("sb_ir_drained", 32'(exp_ir_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Front end of the multi-cycle core. Owns the PC, fetches each instruction from instruction memory over a req/ack handshake and holds it in the instruction register (IR).
- Sequences the five stages IF, ID, EX, MEM, WB and presents opcode/funct to the control unit.
- Applies the control unit's branch/call/ret/halt decisions at WB.
- Contains the return-address stack used by call/ret.

Parameters:
- ADDR_W, 16, PC and instruction-memory word-address width.
- RESET_PC, 0, PC value loaded on reset.
- RAS_DEPTH, 8, return-address stack entries (power of two, at least 2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- imem_req  out  1  fetch request, held high until acknowledged.
- imem_addr  out  ADDR_W  fetch word address (equals PC).
- imem_ack  in  1  instruction-memory acknowledge; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  instruction word.
- branch  in  2  control-unit PC-source select: 00 = sequential, 01 = call/ret, 10 = jump.
- push  in  1  call: push return address.
- pop  in  1  ret: pop return address.
- cond_ok  in  1  jump condition; the control unit ties it high for unconditional jumps.
- jump_target  in  ADDR_W  target for call and jump.
- halt  in  1  halt instruction decoded.
- opcode  out  6  IR[31:26].
- fnction  out  6  IR[5:0].
- instr  out  32  full IR.
- stage  out  3  000 = IF, 001 = ID, 010 = EX, 011 = MEM, 100 = WB, 101 = HALT.
- pc  out  ADDR_W  current PC.
- ras_ovf  out  1  sticky return-stack overflow flag.
- ras_unf  out  1  sticky return-stack underflow flag.

Behaviour:
- Reset is asynchronous, active-low on rst_n; clock is clk.
- Reset values: PC = RESET_PC, IR = 0 (opcode and fnction = 0, i.e. r_type), stage = IF, stack empty, ras_ovf = 0, ras_unf = 0.
- imem_req is 0 while rst_n is low and is asserted combinationally in IF from the first cycle after release.
- imem_req = 1 exactly when stage == IF. imem_addr = PC at all times.
- IF: waits for imem_ack. On an ack cycle, IR <= imem_rdata and stage <= ID on the next edge. Ack with zero wait gives a 1-cycle IF.
- imem_ack outside IF is ignored; IR is unchanged.
- ID -> EX -> MEM -> WB advance one per cycle unconditionally. The IR is stable from ID through WB.
- WB, next-PC resolution evaluated in this priority order:
  - halt = 1: PC unchanged, stage <= HALT.
  - branch == 01 with push: stack[top] <= PC+1 and PC <= jump_target.
  - branch == 01 with pop: PC <= popped entry.
  - branch == 10 with cond_ok = 1: PC <= jump_target.
  - Otherwise: PC <= PC+1.
  - Then stage <= IF, except after halt.
- PC arithmetic is modulo 2^ADDR_W; PC+1 wraps from all-ones to 0.
- push and pop both high in WB is a protocol error: treat as push only. Both are ignored outside WB.
- Stack full plus push: no write, depth unchanged, ras_ovf <= 1. The PC still jumps to jump_target.
- Stack empty plus pop: PC <= PC+1, ras_unf <= 1.
- Overflow and underflow flags clear only on reset.
- Push and pop in the same instruction are never combined, so no simultaneous read/write of the stack occurs.
- HALT is terminal until reset. In HALT: imem_req = 0, all inputs ignored, PC and IR hold.
- Reset mid-fetch (imem_req high) drops the request immediately. An in-flight ack after reset release is not consumed unless the sequencer is in IF, which it is. The memory must therefore reset together with this block.

Decomposition:
- Shared package (core-wide): stage encodings (IF/ID/EX/MEM/WB/HALT), branch select encodings (BR_SEQ = 00, BR_STACK = 01, BR_JUMP = 10), and opcode field positions (OPC_HI = 31, OPC_LO = 26, FN_HI = 5, FN_LO = 0).
- One sub-module, return_addr_stack: parameterised by RAS_DEPTH and ADDR_W; push/pop/data_in/top/full/empty; async reset to empty. The sequencer instantiates it once.

Test Plan:
1. Reset, then 4 sequential r_type instructions with ack the same cycle as req. Required: stage cycles 0,1,2,3,4,0 and pc = 0,1,2,3. Each instruction takes 5 cycles; opcode = 000000.
2. Ack delayed 3 cycles. Required: imem_req held for 4 cycles, imem_addr stable, IR updated only on the ack cycle, instr outside IF ignored.
3. Call at pc 5 (branch = 01, push, jump_target = 20), then ret at pc 20 (branch = 01, pop). Required: pc goes 5, 20, 6; stack depth goes 0, 1, 0.
4. Nine nested calls with RAS_DEPTH = 8. Required: ras_ovf sets on the 9th call, pc = target anyway. Then 9 rets: 8 return correctly, the 9th gives pc+1 and ras_unf = 1.
5. Jump with cond_ok = 0 at pc 10, then cond_ok = 1 with jump_target = 0x0003. Required: pc goes 11, then 3. PC = 0xFFFF sequential wraps to 0x0000.
6. halt at WB. Required: stage = HALT, imem_req = 0, pc frozen for 20 cycles. Then assert rst_n low mid-HALT. Required: pc = RESET_PC, stage = IF.
